// File: rtl/simm_pkg.sv
// Shared constants for the SIMM arbiter and controller.
// State codes, owner ids, bank layout and refresh interval.
package simm_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CPU_CYCLE = 3'd1;
    localparam logic [2:0] ST_DMA_ISSUE = 3'd2;
    localparam logic [2:0] ST_DMA_WAIT  = 3'd3;
    localparam logic [2:0] ST_DMA_DONE  = 3'd4;
    localparam logic [2:0] ST_RECOVER   = 3'd5;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int DEFAULT_BANK_BIT = 24;
    localparam int REFRESH_INTERVAL = 250;

    typedef struct packed {
        logic        rn_w;
        logic [3:0]  byte_selects;
        logic [31:0] addr;
    } dma_cmd_t;

endpackage

// File: rtl/simm_arb_pick.sv
// Two-way round-robin picker between the CPU and DMA requesters.
// On a tie the side that did not own the bus last wins.
module simm_arb_pick
    import simm_pkg::*;
(
    input  logic cpu_pend,
    input  logic dma_pend,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_dma
);

    assign grant_valid = cpu_pend | dma_pend;
    assign grant_dma   = dma_pend & (~cpu_pend | (last_owner == OWNER_CPU));

endmodule

// File: rtl/simm_arbiter.sv
// Shares the SIMM controller between the CPU bus cycle and one DMA master,
// inserting recovery gaps so the controller returns to IDLE between owners.
module simm_arbiter
    import simm_pkg::*;
#(
    parameter int BANK_BIT       = DEFAULT_BANK_BIT,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_as,
    input  logic        cpu_ds,
    input  logic        cpu_rn_w,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byte_selects,
    output logic        cpu_waitstate,
    input  logic        dma_req,
    input  logic        dma_rn_w,
    input  logic [31:0] dma_addr,
    input  logic [3:0]  dma_byte_selects,
    output logic        dma_ack,
    output logic        mem_cs,
    output logic        mem_as,
    output logic        mem_ds,
    output logic        mem_rn_w,
    output logic        mem_bank_addr,
    output logic [3:0]  mem_byte_selects,
    output logic [31:0] mem_addr,
    input  logic        mem_waitstate,
    output logic        owner_dma
);

    localparam int RCW = $clog2(RECOVER_CYCLES + 1);

    logic [2:0]     state;
    logic           last_owner;
    logic [RCW-1:0] rec_cnt;
    dma_cmd_t       dma_lat;

    logic cpu_pend;
    logic grant_valid;
    logic grant_dma;

    assign cpu_pend = cpu_cs & cpu_as & cpu_ds;

    simm_arb_pick u_pick (
        .cpu_pend    (cpu_pend),
        .dma_pend    (dma_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_dma   (grant_dma)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_DMA;
            rec_cnt    <= '0;
            dma_lat    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_valid && grant_dma) begin
                        state   <= ST_DMA_ISSUE;
                        dma_lat <= '{rn_w: dma_rn_w,
                                     byte_selects: dma_byte_selects,
                                     addr: dma_addr};
                    end else if (grant_valid) begin
                        state <= ST_CPU_CYCLE;
                    end
                end
                ST_CPU_CYCLE: begin
                    if (!cpu_as) begin
                        state      <= ST_RECOVER;
                        last_owner <= OWNER_CPU;
                        rec_cnt    <= '0;
                    end
                end
                ST_DMA_ISSUE: state <= ST_DMA_WAIT;
                ST_DMA_WAIT: begin
                    if (!mem_waitstate) begin
                        state <= ST_DMA_DONE;
                    end
                end
                ST_DMA_DONE: begin
                    state      <= ST_RECOVER;
                    last_owner <= OWNER_DMA;
                    rec_cnt    <= '0;
                end
                ST_RECOVER: begin
                    if (rec_cnt == RCW'(RECOVER_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        rec_cnt <= rec_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset drops them immediately.
    always_comb begin
        mem_cs           = 1'b0;
        mem_as           = 1'b0;
        mem_ds           = 1'b0;
        mem_rn_w         = 1'b0;
        mem_byte_selects = 4'b0000;
        mem_addr         = 32'h0;
        cpu_waitstate    = 1'b1;
        dma_ack          = 1'b0;
        owner_dma        = 1'b0;
        unique case (state)
            ST_CPU_CYCLE: begin
                mem_cs           = cpu_cs;
                mem_as           = cpu_as;
                mem_ds           = cpu_ds;
                mem_rn_w         = cpu_rn_w;
                mem_byte_selects = cpu_byte_selects;
                mem_addr         = cpu_addr;
                cpu_waitstate    = mem_waitstate;
            end
            ST_DMA_ISSUE, ST_DMA_WAIT: begin
                mem_cs           = 1'b1;
                mem_as           = 1'b1;
                mem_ds           = 1'b1;
                mem_rn_w         = dma_lat.rn_w;
                mem_byte_selects = dma_lat.byte_selects;
                mem_addr         = dma_lat.addr;
                owner_dma        = 1'b1;
            end
            ST_DMA_DONE: begin
                mem_rn_w  = dma_lat.rn_w;
                mem_addr  = dma_lat.addr;
                dma_ack   = 1'b1;
                owner_dma = 1'b1;
            end
            default: begin
                mem_cs = 1'b0;
            end
        endcase
    end

    assign mem_bank_addr = mem_addr[BANK_BIT];

endmodule
